// File: rtl/sipo_receiver_pkg.sv
// Shared SCI serial-path constants, common to the SIPO receiver and PISO transmitter.
package sipo_receiver_pkg;

    // Default serial word width in bits.
    localparam int unsigned SCI_WORD_W = 8;

    // Bit-order convention on the serial line: the first bit on the wire is the LSB.
    localparam bit SCI_LSB_FIRST = 1'b1;

endpackage

// File: rtl/sipo_receiver_if.sv
// Serial-in / parallel-out bus between a producer/consumer (master) and the receiver (slave).
//   sin, shift_in, clear  : serial bit, bit strobe, synchronous flush (master -> slave)
//   pout, pout_valid      : held word and its valid flag (slave -> master)
//   pout_ready            : consumer accepts pout (master -> slave)
//   busy, overrun         : partial word in progress, sticky dropped-word flag (slave -> master)
interface sipo_receiver_if #(
    parameter int unsigned DEPTH = sipo_receiver_pkg::SCI_WORD_W
);
    logic             sin;
    logic             shift_in;
    logic             clear;
    logic [DEPTH-1:0] pout;
    logic             pout_valid;
    logic             pout_ready;
    logic             busy;
    logic             overrun;

    modport master (
        output sin, shift_in, clear, pout_ready,
        input  pout, pout_valid, busy, overrun
    );

    modport slave (
        input  sin, shift_in, clear, pout_ready,
        output pout, pout_valid, busy, overrun
    );
endinterface

// File: rtl/sipo_receiver_shift_reg.sv
// DEPTH enable flops shifting right, serial input at the MSB.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_en           : shift one bit in
//   i_clr          : synchronous zero, overrides i_en
//   i_sin          : serial bit inserted at bit DEPTH-1
//   o_q            : register contents
module sipo_shift_reg #(
    parameter int unsigned DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_sin,
    output logic [DEPTH-1:0] o_q
);
    logic [DEPTH-1:0] r_q;
    logic [DEPTH-1:0] w_d;

    // Next value: flush on clear, otherwise shift right with new bit at the MSB.
    always_comb begin
        w_d = i_clr ? '0 : {i_sin, r_q[DEPTH-1:1]};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_en || i_clr) begin
            r_q <= w_d;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/sipo_receiver.sv
// SCI serial receiver: assembles DEPTH LSB-first bits into a word held behind valid/ready.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus (slave)    : sin/shift_in/clear in, pout/pout_valid out, pout_ready in, busy/overrun out
module sipo_receiver
    import sipo_receiver_pkg::*;
#(
    parameter int unsigned DEPTH = SCI_WORD_W
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    sipo_receiver_if.slave bus
);
    localparam int unsigned CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DEPTH - 1);

    localparam logic [0:0] HOLD_EMPTY = 1'b0;
    localparam logic [0:0] HOLD_FULL  = 1'b1;

    logic [0:0]       r_state,   w_state_nx;
    logic [CNT_W-1:0] r_count,   w_count_nx;
    logic [DEPTH-1:0] r_pout,    w_pout_nx;
    logic             r_overrun, w_overrun_nx;
    logic             r_busy,    w_busy_nx;

    logic [DEPTH-1:0] w_shift_q;
    logic [DEPTH-1:0] w_word;
    logic             w_accept;
    logic             w_complete;
    logic             w_unused_q0;

    assign w_accept   = bus.shift_in && !bus.clear;
    assign w_complete = w_accept && (r_count == LAST_BIT);
    // Completed word includes the bit being sampled this cycle; shift bit 0 is about to fall off.
    assign w_word      = {bus.sin, w_shift_q[DEPTH-1:1]};
    assign w_unused_q0 = w_shift_q[0];

    sipo_shift_reg #(.DEPTH(DEPTH)) u_shift (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_accept),
        .i_clr   (bus.clear),
        .i_sin   (bus.sin),
        .o_q     (w_shift_q)
    );

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= HOLD_EMPTY;
            r_count   <= '0;
            r_pout    <= '0;
            r_overrun <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_count   <= w_count_nx;
            r_pout    <= w_pout_nx;
            r_overrun <= w_overrun_nx;
            r_busy    <= w_busy_nx;
        end
    end

    // Next-state: bit counter, holding register and overrun; clear overrides all.
    always_comb begin
        w_state_nx   = r_state;
        w_count_nx   = r_count;
        w_pout_nx    = r_pout;
        w_overrun_nx = r_overrun;

        if (bus.clear) begin
            w_state_nx   = HOLD_EMPTY;
            w_count_nx   = '0;
            w_pout_nx    = '0;
            w_overrun_nx = 1'b0;
        end else begin
            if (w_accept) begin
                w_count_nx = w_complete ? '0 : r_count + CNT_W'(1);
            end
            case (r_state)
                HOLD_EMPTY: begin
                    if (w_complete) begin
                        w_pout_nx  = w_word;
                        w_state_nx = HOLD_FULL;
                    end
                end
                HOLD_FULL: begin
                    if (bus.pout_ready) begin
                        if (w_complete) begin
                            w_pout_nx = w_word;
                        end else begin
                            w_state_nx = HOLD_EMPTY;
                        end
                    end else if (w_complete) begin
                        // Held word is unconsumed: drop the new one.
                        w_overrun_nx = 1'b1;
                    end
                end
                default: begin
                    w_state_nx = HOLD_EMPTY;
                end
            endcase
        end

        w_busy_nx = (w_count_nx != '0);
    end

    assign bus.pout       = r_pout;
    assign bus.pout_valid = (r_state == HOLD_FULL);
    assign bus.busy       = r_busy;
    assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_sipo_receiver.sv
module tb_sipo_receiver;
    localparam int unsigned DEPTH = 8;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   busy_err = 0;
    logic [DEPTH-1:0] exp_q[$];

    sipo_receiver_if #(.DEPTH(DEPTH)) bus ();

    sipo_receiver #(.DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One strobed bit, then gap idle cycles; optionally tracks BUSY after each edge.
    task automatic send_bit(input logic b, input int gap, input bit exp_busy, input bit track);
        bus.sin      = b;
        bus.shift_in = 1'b1;
        @(posedge clk);
        #1;
        bus.shift_in = 1'b0;
        if (track && (bus.busy !== exp_busy)) busy_err++;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
            if (track && (bus.busy !== exp_busy)) busy_err++;
        end
    endtask

    task automatic send_word(input logic [DEPTH-1:0] w, input int gap, input bit track);
        for (int i = 0; i < DEPTH; i++) begin
            send_bit(w[i], gap, (i != DEPTH - 1), track);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: a transfer happens at the next rising edge whenever valid and ready are high now.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.pout_valid && bus.pout_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got 0x%0h expected none at %0t", bus.pout, $time);
                end else begin
                    check("word_out", 32'(bus.pout), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n          = 1'b0;
        bus.sin        = 1'b0;
        bus.shift_in   = 1'b0;
        bus.clear      = 1'b0;
        bus.pout_ready = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);

        check("rst_pout",    32'(bus.pout), 32'h0);
        check("rst_valid",   32'(bus.pout_valid), 32'h0);
        check("rst_busy",    32'(bus.busy), 32'h0);
        check("rst_overrun", 32'(bus.overrun), 32'h0);

        // 0xA5 continuous, ready high.
        bus.pout_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_word(8'hA5, 0, 1'b0);
        check("a5_valid", 32'(bus.pout_valid), 32'h1);
        check("a5_pout",  32'(bus.pout), 32'hA5);
        idle(1);
        check("a5_valid_drop", 32'(bus.pout_valid), 32'h0);
        check("a5_pout_keep",  32'(bus.pout), 32'hA5);

        // 0x3C then 0xC3 back-to-back; ready rises in the completion cycle of 0xC3.
        bus.pout_ready = 1'b0;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        send_word(8'h3C, 0, 1'b0);
        check("3c_valid", 32'(bus.pout_valid), 32'h1);
        check("3c_pout",  32'(bus.pout), 32'h3C);
        for (int i = 0; i < DEPTH - 1; i++) send_bit(1'(8'hC3 >> i), 0, 1'b0, 1'b0);
        check("3c_stable", 32'(bus.pout), 32'h3C);
        bus.pout_ready = 1'b1;
        send_bit(1'b1, 0, 1'b0, 1'b0);
        check("c3_valid_nogap", 32'(bus.pout_valid), 32'h1);
        check("c3_pout",        32'(bus.pout), 32'hC3);
        check("c3_overrun",     32'(bus.overrun), 32'h0);
        idle(1);
        check("c3_valid_drop", 32'(bus.pout_valid), 32'h0);

        // Overrun: ready low, 0x11 then 0x22.
        bus.pout_ready = 1'b0;
        send_word(8'h11, 0, 1'b0);
        check("ov_first_pout",    32'(bus.pout), 32'h11);
        check("ov_first_overrun", 32'(bus.overrun), 32'h0);
        send_word(8'h22, 0, 1'b0);
        check("ov_pout_kept", 32'(bus.pout), 32'h11);
        check("ov_valid",     32'(bus.pout_valid), 32'h1);
        check("ov_overrun",   32'(bus.overrun), 32'h1);
        check("ov_busy",      32'(bus.busy), 32'h0);
        bus.clear = 1'b1;
        idle(1);
        bus.clear = 1'b0;
        check("clr_valid",   32'(bus.pout_valid), 32'h0);
        check("clr_overrun", 32'(bus.overrun), 32'h0);
        check("clr_pout",    32'(bus.pout), 32'h0);

        // Gapped strobes, 0x5A, BUSY tracked each cycle.
        bus.pout_ready = 1'b1;
        check("gap_busy_before", 32'(bus.busy), 32'h0);
        busy_err = 0;
        exp_q.push_back(8'h5A);
        send_word(8'h5A, 3, 1'b1);
        check("gap_busy_profile", 32'(busy_err), 32'h0);
        idle(1);
        check("gap_pout", 32'(bus.pout), 32'h5A);

        // Clear after 5 bits with a simultaneous strobe, then 0xFF.
        for (int i = 0; i < 5; i++) send_bit(1'(i & 1), 0, 1'b0, 1'b0);
        check("mid_busy", 32'(bus.busy), 32'h1);
        bus.clear    = 1'b1;
        bus.sin      = 1'b1;
        bus.shift_in = 1'b1;
        idle(1);
        bus.clear    = 1'b0;
        bus.shift_in = 1'b0;
        check("clr_busy",  32'(bus.busy), 32'h0);
        check("clr_valid2", 32'(bus.pout_valid), 32'h0);
        exp_q.push_back(8'hFF);
        send_word(8'hFF, 0, 1'b0);
        check("ff_pout", 32'(bus.pout), 32'hFF);
        idle(2);

        // Async reset mid-word, then 0x81.
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0, 1'b0, 1'b0);
        check("pre_rst_busy", 32'(bus.busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pout",    32'(bus.pout), 32'h0);
        check("arst_valid",   32'(bus.pout_valid), 32'h0);
        check("arst_busy",    32'(bus.busy), 32'h0);
        check("arst_overrun", 32'(bus.overrun), 32'h0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(8'h81);
        send_word(8'h81, 0, 1'b0);
        check("81_pout",  32'(bus.pout), 32'h81);
        check("81_valid", 32'(bus.pout_valid), 32'h1);
        idle(3);

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sipo_receiver.md
# sipo_receiver

Serial-in/parallel-out receiver for the SCI serial path: the receiving end of the PISO transmit buffer. Collects DEPTH bits, LSB first, on a per-bit strobe, assembles them into a word, and presents the word on a valid/ready parallel output backed by a holding register. Shifting of the next word continues while the previous word waits to be consumed. Overruns are flagged rather than silently corrupting data.

## Interface
- DEPTH, 8, word width in bits; legal range ≥ 2.
- CLK  in  1  system clock, rising-edge.
- RSTN  in  1  reset, asynchronous and active-low.
- SIN  in  1  serial data bit, sampled when SHIFT_IN=1.
- SHIFT_IN  in  1  bit strobe; one bit accepted per cycle it is high.
- CLEAR  in  1  synchronous abort and flush.
- POUT  out  DEPTH  assembled word from the holding register.
- POUT_VALID  out  1  POUT holds an unconsumed word.
- POUT_READY  in  1  consumer accepts POUT.
- BUSY  out  1  partial word in progress (bit count ≠ 0).
- OVERRUN  out  1  sticky; a completed word was dropped.

## Operation
- Bit order:
  - The first bit received is the LSB. It ends in POUT[0], matching the PISO transmitter, which shifts out through its LSB.
  - The shift register shifts right and inserts SIN at bit DEPTH-1.
- Bit counter:
  - Width $clog2(DEPTH).
  - Increments on each accepted bit.
  - Wraps from DEPTH-1 to 0 on the bit that completes a word.
- Word completion is the SHIFT_IN cycle in which count = DEPTH-1. The completed word is {SIN, shift[DEPTH-1:1]}.
- Holding register has two states, EMPTY (POUT_VALID=0) and FULL (POUT_VALID=1):
  - EMPTY + completion: load word and go to FULL.
  - FULL + POUT_READY without completion: go to EMPTY. POUT keeps its last value.
  - FULL + POUT_READY + completion: load new word and stay FULL. No bubble.
  - FULL + no POUT_READY + completion: drop the new word, keep the held word, set OVERRUN. The counter still wraps to 0.
- CLEAR:
  - Has priority over everything else.
  - Zeroes the counter, shift register and OVERRUN, and sets POUT_VALID=0.
  - POUT is zeroed.
  - A SHIFT_IN in the same cycle is ignored.
- OVERRUN is cleared only by CLEAR or RSTN.
- SHIFT_IN=0 holds the counter and shift register. There is no timeout; a partial word waits indefinitely.

## Timing
- Reset values: POUT=0, POUT_VALID=0, BUSY=0, OVERRUN=0. The counter and shift register are also 0.
- Reset mid-word discards the partial word immediately (asynchronous).
- All outputs are registered; there is no combinational path from input to output.
- Latency: POUT and POUT_VALID update on the same rising edge that samples the DEPTH-th bit.
- Handshake:
  - Transfer occurs at a rising edge where POUT_VALID=1 and POUT_READY=1.
  - POUT_VALID may not depend on POUT_READY.
  - POUT is stable while POUT_VALID=1 and no transfer occurs.
- Throughput: sustained SHIFT_IN=1 gives one word per DEPTH cycles. Back-to-back words are lossless if POUT_READY is high at least once per DEPTH cycles.
- BUSY is high from the edge after the first accepted bit until the edge that completes the word.

## Structure
- Shared SCI package/header holds:
  - the default word width constant (8);
  - the bit-order convention constant (LSB-first), shared with the PISO transmitter.
- Sub-module sipo_shift_reg contains DEPTH enable flops (D_FF_EN, RSTN wired to the block reset) with serial input at the MSB.
- The counter, holding register, valid/overrun logic and CLEAR handling stay in sipo_receiver.

## Test plan
- DEPTH=8: send 0xA5 LSB-first (bits 1,0,1,0,0,1,0,1) with SHIFT_IN continuous and POUT_READY=1.
  - POUT=0xA5 and POUT_VALID=1 right after the 8th edge.
  - POUT_VALID=0 one cycle later.
- Back-to-back 0x3C then 0xC3 with POUT_READY held low until after the first word.
  - Words are delivered in order.
  - No OVERRUN.
  - POUT_VALID has no gap when READY rises in the completion cycle of 0xC3.
- POUT_READY=0 throughout, send 0x11 then 0x22.
  - POUT stays 0x11.
  - OVERRUN=1 after the 16th bit edge.
  - After CLEAR, POUT_VALID=0 and OVERRUN=0.
- Gapped strobes: send 0x5A with SHIFT_IN low for 3 cycles between every bit.
  - POUT=0x5A.
  - BUSY high throughout, except before the first bit and after completion.
- After 5 bits, assert CLEAR with SHIFT_IN=1, then send 0xFF.
  - The first word out is 0xFF, not a mixture.
  - BUSY=0 on the edge after CLEAR.
- After 4 bits of 0x0F, pulse RSTN low asynchronously between edges.
  - All outputs are 0 immediately.
  - A following 0x81 is received intact.
